// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with saturating direction counters and branch/mispredict statistics.
// Lookup is combinational from registered state; updates, flush and reset take effect at the next CLK edge.
module branch_target_buffer #(
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2,
  parameter int CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [31:0]      lookup_pc,
  output logic             hit,
  output logic             predict_taken,
  output logic [31:0]      predict_target,
  input  logic             upd_en,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic             flush_all,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int IW = $clog2(ENTRIES);
  localparam int TW = 30 - IW;
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1 << (CTR_BITS - 1));

  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [TW-1:0]       tag_q [ENTRIES];
  logic [31:0]         tgt_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q [ENTRIES];
  logic [CNT_W-1:0]    bc_q, bc_d;
  logic [CNT_W-1:0]    mc_q, mc_d;

  logic [IW-1:0]       lk_idx, up_idx;
  logic [TW-1:0]       lk_tag, up_tag;
  logic                up_hit, up_pred_taken, up_mispredict;
  logic [31:0]         up_pred_target;
  logic [CTR_BITS-1:0] ctr_cur, ctr_inc, ctr_dec, ent_ctr_d;
  logic                ent_we, ent_tgt_we;
  logic                unused_pc_bits;

  assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign lk_idx         = lookup_pc[IW+1:2];
  assign lk_tag         = lookup_pc[31:IW+2];
  assign hit            = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign predict_taken  = hit && ctr_q[lk_idx][CTR_BITS-1];
  assign predict_target = predict_taken ? tgt_q[lk_idx] : lookup_pc + 32'd4;

  // Update-side prediction mirrors the lookup path but is evaluated on upd_pc.
  assign up_idx         = upd_pc[IW+1:2];
  assign up_tag         = upd_pc[31:IW+2];
  assign up_hit         = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_pred_taken  = up_hit && ctr_q[up_idx][CTR_BITS-1];
  assign up_pred_target = up_pred_taken ? tgt_q[up_idx] : upd_pc + 32'd4;
  assign up_mispredict  = (up_pred_taken != upd_taken) ||
                          (upd_taken && (up_pred_target != upd_target));

  assign ctr_cur = ctr_q[up_idx];
  assign ctr_inc = (ctr_cur == '1) ? ctr_cur : ctr_cur + CTR_BITS'(1);
  assign ctr_dec = (ctr_cur == '0) ? ctr_cur : ctr_cur - CTR_BITS'(1);

  always_comb begin
    valid_d    = valid_q;
    bc_d       = bc_q;
    mc_d       = mc_q;
    ent_we     = 1'b0;
    ent_tgt_we = 1'b0;
    ent_ctr_d  = ctr_cur;
    if (flush_all) begin
      valid_d = '0;
    end else if (upd_en) begin
      bc_d = (bc_q == '1) ? bc_q : bc_q + CNT_W'(1);
      if (up_mispredict) begin
        mc_d = (mc_q == '1) ? mc_q : mc_q + CNT_W'(1);
      end
      if (up_hit) begin
        ent_we     = 1'b1;
        ent_tgt_we = upd_taken;
        ent_ctr_d  = upd_taken ? ctr_inc : ctr_dec;
      end else if (upd_taken) begin
        ent_we          = 1'b1;
        ent_tgt_we      = 1'b1;
        ent_ctr_d       = CTR_WEAK;
        valid_d[up_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      valid_q <= '0;
      bc_q    <= '0;
      mc_q    <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      bc_q    <= bc_d;
      mc_q    <= mc_d;
      if (ent_we) begin
        ctr_q[up_idx] <= ent_ctr_d;
      end
    end
  end

  // Tags and targets are only meaningful behind a valid bit, so they carry no reset.
  always_ff @(posedge CLK) begin
    if (!nRST && ent_we) begin
      tag_q[up_idx] <= up_tag;
    end
    if (!nRST && ent_tgt_we) begin
      tgt_q[up_idx] <= upd_target;
    end
  end

  assign branch_count     = bc_q;
  assign mispredict_count = mc_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench: the driver pushes expected lookup/statistics values from a table model, a monitor checks them.
module tb_branch_target_buffer;

  localparam int N   = 16;
  localparam int CTR = 2;

  logic        CLK, nRST;
  logic [31:0] lookup_pc, upd_pc, upd_target;
  logic        upd_en, upd_taken, flush_all;
  logic        d_hit, d_pt, d2_hit, d2_pt;
  logic [31:0] d_ptgt, d2_ptgt;
  logic [15:0] d_bc, d_mc;
  logic [1:0]  d2_bc, d2_mc;

  branch_target_buffer #(.ENTRIES(N), .CTR_BITS(CTR), .CNT_W(16)) dut (
    .CLK(CLK), .nRST(nRST), .lookup_pc(lookup_pc), .hit(d_hit), .predict_taken(d_pt),
    .predict_target(d_ptgt), .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .flush_all(flush_all), .branch_count(d_bc), .mispredict_count(d_mc));

  branch_target_buffer #(.ENTRIES(N), .CTR_BITS(CTR), .CNT_W(2)) dut2 (
    .CLK(CLK), .nRST(nRST), .lookup_pc(lookup_pc), .hit(d2_hit), .predict_taken(d2_pt),
    .predict_target(d2_ptgt), .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .flush_all(flush_all), .branch_count(d2_bc), .mispredict_count(d2_mc));

  typedef struct {
    logic        hit;
    logic        pt;
    logic [31:0] ptgt;
    int          bc, mc, bc2, mc2;
  } exp_t;

  exp_t expq[$];
  int   tests = 0, fails = 0, cyc = 0;

  // Reference table: plain integers, counters as bounded ints.
  bit          m_v   [N];
  logic [31:0] m_tag [N];
  logic [31:0] m_tgt [N];
  int          m_ctr [N];
  int          m_bc, m_mc;

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic exp_t mk(input logic h, input logic t, input logic [31:0] tg, input int bc, input int mc);
    exp_t e;
    e.hit = h; e.pt = t; e.ptgt = tg;
    e.bc = imin(bc, 65535); e.mc = imin(mc, 65535);
    e.bc2 = imin(bc, 3);    e.mc2 = imin(mc, 3);
    return e;
  endfunction

  function automatic exp_t model_look(input logic [31:0] pc);
    int   idx;
    logic h, t;
    idx = int'((pc >> 2) % N);
    h = m_v[idx] && (m_tag[idx] == (pc >> 6));
    t = h && (m_ctr[idx] >= (1 << (CTR - 1)));
    return mk(h, t, t ? m_tgt[idx] : pc + 32'd4, m_bc, m_mc);
  endfunction

  function automatic void model_apply(input logic ue, input logic [31:0] upc, input logic ut,
                                      input logic [31:0] utgt, input logic fl, input logic rst);
    exp_t p;
    int   idx;
    idx = int'((upc >> 2) % N);
    if (rst) begin
      for (int i = 0; i < N; i++) begin m_v[i] = 0; m_ctr[i] = 0; end
      m_bc = 0; m_mc = 0;
    end else if (fl) begin
      for (int i = 0; i < N; i++) m_v[i] = 0;
    end else if (ue) begin
      p = model_look(upc);
      m_bc++;
      if ((p.pt != ut) || (ut && p.ptgt != utgt)) m_mc++;
      if (p.hit) begin
        m_ctr[idx] = ut ? imin(m_ctr[idx] + 1, (1 << CTR) - 1) : ((m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0);
        if (ut) m_tgt[idx] = utgt;
      end else if (ut) begin
        m_v[idx] = 1; m_tag[idx] = upc >> 6; m_tgt[idx] = utgt; m_ctr[idx] = 1 << (CTR - 1);
      end
    end
  endfunction

  // Drives one cycle; e is the model's view of the outputs during that cycle.
  task automatic drive(input logic [31:0] lpc, input logic ue, input logic [31:0] upc, input logic ut,
                       input logic [31:0] utgt, input logic fl, input logic rst, output exp_t e);
    @(posedge CLK); #1;
    nRST = rst; lookup_pc = lpc; upd_en = ue; upd_pc = upc;
    upd_taken = ut; upd_target = utgt; flush_all = fl;
    e = model_look(lpc);
    model_apply(ue, upc, ut, utgt, fl, rst);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, want);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      cyc++;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("hit", {31'd0, d_hit}, {31'd0, e.hit});
        check("predict_taken", {31'd0, d_pt}, {31'd0, e.pt});
        check("predict_target", d_ptgt, e.ptgt);
        check("branch_count", {16'd0, d_bc}, e.bc);
        check("mispredict_count", {16'd0, d_mc}, e.mc);
        check("hit_w2", {31'd0, d2_hit}, {31'd0, e.hit});
        check("branch_count_w2", {30'd0, d2_bc}, e.bc2);
        check("mispredict_count_w2", {30'd0, d2_mc}, e.mc2);
      end
    end
  end

  function automatic logic [31:0] rpc();
    logic [31:0] p;
    p = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
    if ($urandom_range(0, 7) == 0) p = p | ($urandom_range(1, 15) << 28);
    return p;
  endfunction

  initial begin
    exp_t        e;
    logic [31:0] lpc, upc, utgt;
    logic        ue, ut, fl, rst;
    int          r;
    nRST = 1; lookup_pc = 0; upd_en = 0; upd_pc = 0; upd_taken = 0; upd_target = 0; flush_all = 0;

    drive(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, e);
    drive(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, e);
    // Directed vectors with hand-derived expectations.
    drive(32'h40, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, e); expq.push_back(mk(0, 0, 32'h44,  0, 0));
    drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 1'b0, e); expq.push_back(mk(0, 0, 32'h44,  0, 0));
    drive(32'h40, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, e); expq.push_back(mk(1, 1, 32'h100, 1, 1));
    drive(32'h40, 1'b1, 32'h40, 1'b0, 32'h0,   1'b0, 1'b0, e); expq.push_back(mk(1, 1, 32'h100, 1, 1));
    drive(32'h40, 1'b1, 32'h40, 1'b0, 32'h0,   1'b0, 1'b0, e); expq.push_back(mk(1, 0, 32'h44,  2, 2));
    drive(32'h40, 1'b1, 32'h40, 1'b0, 32'h0,   1'b0, 1'b0, e); expq.push_back(mk(1, 0, 32'h44,  3, 2));
    drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 1'b0, e); expq.push_back(mk(1, 0, 32'h44,  4, 2));
    drive(32'h40, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, e); expq.push_back(mk(1, 0, 32'h44,  5, 3));
    drive(32'h80, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, e); expq.push_back(mk(0, 0, 32'h84,  5, 3));
    drive(32'h80, 1'b1, 32'h80, 1'b1, 32'h300, 1'b0, 1'b0, e); expq.push_back(mk(0, 0, 32'h84,  5, 3));
    drive(32'h40, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, e); expq.push_back(mk(0, 0, 32'h44,  6, 4));
    drive(32'h80, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, e); expq.push_back(mk(1, 1, 32'h300, 6, 4));
    drive(32'h80, 1'b1, 32'h200, 1'b1, 32'h400, 1'b1, 1'b0, e); expq.push_back(mk(1, 1, 32'h300, 6, 4));
    drive(32'h80, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, e); expq.push_back(mk(0, 0, 32'h84,  6, 4));
    drive(32'h200, 1'b0, 32'h0, 1'b0, 32'h0,   1'b0, 1'b0, e); expq.push_back(mk(0, 0, 32'h204, 6, 4));
    drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 1'b1, e);
    drive(32'h40, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, e); expq.push_back(mk(0, 0, 32'h44,  0, 0));

    for (int i = 0; i < 3000; i++) begin
      r    = $urandom_range(0, 999);
      rst  = (r < 5);
      fl   = (r >= 5 && r < 25);
      ue   = ($urandom_range(0, 1) == 1);
      ut   = ($urandom_range(0, 9) < 6);
      upc  = rpc();
      lpc  = ($urandom_range(0, 3) == 0) ? upc : rpc();
      utgt = 32'h1000 + ($urandom_range(0, 3) << 4);
      drive(lpc, ue, upc, ut, utgt, fl, rst, e);
      if (!rst) expq.push_back(e);
    end

    repeat (3) @(posedge CLK);
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL drain pending=%0d required=0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
